// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register and processor status register (SR).
// Latches decoded operands and control from ID for the execute stage and
// captures ALU flags into SR for flag-setting instructions. Supports stall,
// hazard bubbles and branch flush, including a flush raised during a stall
// (remembered in flush_pending and applied when the stall releases).
// There is no valid/ready handshake here: stall is a global hold, and
// exe_valid qualifies every registered control bit.
module id_exe_stage_reg #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          hazard,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_exe_cmd,
    input  logic [DW-1:0] id_val_rn,
    input  logic [DW-1:0] id_val2,
    input  logic [RW-1:0] id_dest,
    input  logic          id_wb_en,
    input  logic          id_mem_r,
    input  logic          id_mem_w,
    input  logic          id_s,
    input  logic          id_b,
    input  logic [DW-1:0] id_pc,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic          exe_valid,
    output logic [3:0]    exe_cmd,
    output logic [DW-1:0] exe_val_rn,
    output logic [DW-1:0] exe_val2,
    output logic [RW-1:0] exe_dest,
    output logic          exe_wb_en,
    output logic          exe_mem_r,
    output logic          exe_mem_w,
    output logic          exe_s,
    output logic          exe_b,
    output logic [DW-1:0] exe_pc,
    output logic          alu_cin,
    output logic [3:0]    sr
);

    // A flush seen while stalled, still waiting to squash the next load.
    logic flush_pending;

    // Squash: a live flush or one remembered across a stall.
    logic squash;
    // Bubble: squash or a data hazard; controls and valid are forced low.
    logic bubble;

    // Bubble selection for the next register load.
    always_comb begin
        squash = flush | flush_pending;
        bubble = squash | hazard;
    end

    // ID/EXE register: hold on stall, otherwise load ID with controls gated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid     <= 1'b0;
            exe_cmd       <= 4'd0;
            exe_val_rn    <= '0;
            exe_val2      <= '0;
            exe_dest      <= '0;
            exe_wb_en     <= 1'b0;
            exe_mem_r     <= 1'b0;
            exe_mem_w     <= 1'b0;
            exe_s         <= 1'b0;
            exe_b         <= 1'b0;
            exe_pc        <= '0;
            flush_pending <= 1'b0;
        end else if (stall) begin
            // Everything holds; only remember a flush for later.
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else begin
            // Data fields always follow ID; they are don't-care in a bubble.
            exe_cmd    <= id_exe_cmd;
            exe_val_rn <= id_val_rn;
            exe_val2   <= id_val2;
            exe_dest   <= id_dest;
            exe_pc     <= id_pc;
            if (bubble) begin
                exe_valid <= 1'b0;
                exe_wb_en <= 1'b0;
                exe_mem_r <= 1'b0;
                exe_mem_w <= 1'b0;
                exe_s     <= 1'b0;
                exe_b     <= 1'b0;
            end else begin
                exe_valid <= id_valid;
                exe_wb_en <= id_wb_en & id_valid;
                exe_mem_r <= id_mem_r & id_valid;
                exe_mem_w <= id_mem_w & id_valid;
                exe_s     <= id_s & id_valid;
                exe_b     <= id_b & id_valid;
            end
            if (squash) begin
                flush_pending <= 1'b0;
            end
        end
    end

    // Status register: commit flags of the instruction leaving EXE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= 4'b0000;
        end else if (!stall && exe_valid && exe_s) begin
            sr <= {alu_n, alu_z, alu_c, alu_v};
        end
    end

    // Carry-in comes straight from SR; no bypass is needed because SR
    // updates on the same edge the next instruction enters EXE.
    always_comb begin
        alu_cin = sr[1];
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: reset, normal flow, invalid ID,
// hazard bubble, stall with flush, hazard+flush, reset mid-stall, SUB->ADC.
module tb_id_exe_stage_reg;

    localparam int DW = 32;
    localparam int RW = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          stall, hazard, flush, id_valid;
    logic [3:0]    id_exe_cmd;
    logic [DW-1:0] id_val_rn, id_val2, id_pc;
    logic [RW-1:0] id_dest;
    logic          id_wb_en, id_mem_r, id_mem_w, id_s, id_b;
    logic          alu_n, alu_z, alu_c, alu_v;
    logic          exe_valid;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] exe_val_rn, exe_val2, exe_pc;
    logic [RW-1:0] exe_dest;
    logic          exe_wb_en, exe_mem_r, exe_mem_w, exe_s, exe_b;
    logic          alu_cin;
    logic [3:0]    sr;

    int n_cmp = 0;
    int n_bad = 0;

    id_exe_stage_reg #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .hazard(hazard), .flush(flush),
        .id_valid(id_valid), .id_exe_cmd(id_exe_cmd), .id_val_rn(id_val_rn),
        .id_val2(id_val2), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_s(id_s), .id_b(id_b),
        .id_pc(id_pc), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_val_rn(exe_val_rn),
        .exe_val2(exe_val2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r), .exe_mem_w(exe_mem_w), .exe_s(exe_s), .exe_b(exe_b),
        .exe_pc(exe_pc), .alu_cin(alu_cin), .sr(sr)
    );

    // Comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: load one ID instruction
    task automatic drive_id(input logic v, input logic [3:0] cmd, input logic [31:0] rn,
                            input logic [31:0] v2, input logic wb, input logic s);
        id_valid   = v;
        id_exe_cmd = cmd;
        id_val_rn  = rn;
        id_val2    = v2;
        id_dest    = 4'd5;
        id_wb_en   = wb;
        id_mem_r   = 1'b0;
        id_mem_w   = 1'b0;
        id_s       = s;
        id_b       = 1'b0;
        id_pc      = 32'h0000_0100;
    endtask

    task automatic flags(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'd0, exe_valid}, 32'd0);
        check({tag, "_ctrl"}, {27'd0, exe_wb_en, exe_mem_r, exe_mem_w, exe_s, exe_b}, 32'd0);
    endtask

    initial begin
        // Reset with every ID input driven high
        rst = 1'b0; stall = 1'b0; hazard = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_exe_cmd = 4'hF; id_val_rn = '1; id_val2 = '1;
        id_dest = '1; id_wb_en = 1'b1; id_mem_r = 1'b1; id_mem_w = 1'b1;
        id_s = 1'b1; id_b = 1'b1; id_pc = '1;
        flags(4'b1111);
        #2;
        check("rst_valid", {31'd0, exe_valid}, 32'd0);
        check("rst_ctrl", {27'd0, exe_wb_en, exe_mem_r, exe_mem_w, exe_s, exe_b}, 32'd0);
        check("rst_cmd", {28'd0, exe_cmd}, 32'd0);
        check("rst_rn", exe_val_rn, 32'd0);
        check("rst_val2", exe_val2, 32'd0);
        check("rst_pc", exe_pc, 32'd0);
        check("rst_dest", {28'd0, exe_dest}, 32'd0);
        check("rst_sr", {28'd0, sr}, 32'd0);
        check("rst_cin", {31'd0, alu_cin}, 32'd0);
        step(); step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_hold_valid", {31'd0, exe_valid}, 32'd0);
        check("rst_hold_rn", exe_val_rn, 32'd0);

        // Normal flow: rn=-12, val2=20, cmd=2, s=1, flags C=1
        drive_id(1'b1, 4'd2, 32'hFFFF_FFF4, 32'd20, 1'b1, 1'b1);
        flags(4'b0010);
        step();
        check("nf_rn", exe_val_rn, 32'hFFFF_FFF4);
        check("nf_val2", exe_val2, 32'd20);
        check("nf_cmd", {28'd0, exe_cmd}, 32'd2);
        check("nf_valid", {31'd0, exe_valid}, 32'd1);
        check("nf_s", {31'd0, exe_s}, 32'd1);
        check("nf_wb", {31'd0, exe_wb_en}, 32'd1);
        check("nf_dest", {28'd0, exe_dest}, 32'd5);
        check("nf_pc", exe_pc, 32'h0000_0100);
        check("nf_sr_before", {28'd0, sr}, 32'd0);

        // Invalid ID with live-looking control
        drive_id(1'b0, 4'd1, 32'd7, 32'd8, 1'b1, 1'b1);
        step();
        check("nf_sr", {28'd0, sr}, 32'b0010);
        check("nf_cin", {31'd0, alu_cin}, 32'd1);
        check_bubble("inv");
        flags(4'b1111);
        step();
        check("inv_sr_hold", {28'd0, sr}, 32'b0010);

        // Hazard: EXE instruction with s=1 still commits while bubble loads
        drive_id(1'b1, 4'd4, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        drive_id(1'b1, 4'd3, 32'd3, 32'd4, 1'b0, 1'b1);
        hazard = 1'b1;
        flags(4'b1000);
        step();
        check_bubble("hz");
        check("hz_sr", {28'd0, sr}, 32'b1000);
        check("hz_cin", {31'd0, alu_cin}, 32'd0);
        hazard = 1'b0;
        flags(4'b0111);
        step();
        check("hz_after_valid", {31'd0, exe_valid}, 32'd1);
        check("hz_after_cmd", {28'd0, exe_cmd}, 32'd3);
        check("hz_after_sr", {28'd0, sr}, 32'b1000);

        // Stall 3 cycles with flush in cycle 1; EXE holds cmd 3, s=1
        flags(4'b0101);
        stall = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_id(1'b1, 4'd7, 32'd9, 32'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("st_cmd", {28'd0, exe_cmd}, 32'd3);
            check("st_valid", {31'd0, exe_valid}, 32'd1);
            check("st_rn", exe_val_rn, 32'd3);
            check("st_sr", {28'd0, sr}, 32'b1000);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        check_bubble("st_rel");
        check("st_rel_sr", {28'd0, sr}, 32'b0101);
        step();
        check("st_next_valid", {31'd0, exe_valid}, 32'd1);
        check("st_next_cmd", {28'd0, exe_cmd}, 32'd7);
        check("st_next_wb", {31'd0, exe_wb_en}, 32'd1);

        // Hazard and flush together, pending must end cleared
        hazard = 1'b1;
        flush = 1'b1;
        step();
        check_bubble("hf");
        hazard = 1'b0;
        flush = 1'b0;
        step();
        check("hf_next_valid", {31'd0, exe_valid}, 32'd1);

        // Reset mid-stall discards a pending flush
        stall = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        rst = 1'b0;
        #1;
        check("rs_valid", {31'd0, exe_valid}, 32'd0);
        check("rs_sr", {28'd0, sr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        drive_id(1'b1, 4'd9, 32'd11, 32'd12, 1'b1, 1'b0);
        step();
        check("rs_valid_after", {31'd0, exe_valid}, 32'd1);
        check("rs_wb_after", {31'd0, exe_wb_en}, 32'd1);

        // SUB (s=1, C=1) directly followed by ADC
        drive_id(1'b1, 4'd4, 32'd5, 32'd3, 1'b1, 1'b1);
        flags(4'b0000);
        step();
        check("b2b_cin_before", {31'd0, alu_cin}, 32'd0);
        drive_id(1'b1, 4'd3, 32'd6, 32'd1, 1'b1, 1'b0);
        flags(4'b0010);
        step();
        check("b2b_cmd", {28'd0, exe_cmd}, 32'd3);
        check("b2b_cin", {31'd0, alu_cin}, 32'd1);
        check("b2b_sr", {28'd0, sr}, 32'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
